// File: rtl/nasti_ctrl_pkg.sv
// Shared types for the nasti_demux ordering guard: port index, tracker FSM states.
package nasti_ctrl_pkg;

  localparam int NASTI_MAX_PORTS = 8;

  typedef logic [2:0] port_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } trk_state_e;

endpackage

// File: rtl/nasti_txn_tracker.sv
// One channel's ordering guard: outstanding-burst counter, port lock and handshake gating.
module nasti_txn_tracker
  import nasti_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_s_valid,
  output logic      o_s_ready,
  input  port_idx_t i_req_port,
  output logic      o_m_valid,
  input  logic      i_m_ready,
  input  logic      i_done,
  output logic      o_busy,
  output port_idx_t o_port,
  output logic      o_err
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  trk_state_e           r_state;
  trk_state_e           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  port_idx_t            r_port;
  port_idx_t            w_port_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 w_allow;
  logic                 w_issue;

  // Gating depends only on registered state and the request port, never on i_done.
  assign w_allow   = (r_state == IDLE) || ((i_req_port == r_port) && (r_cnt < MAX_CNT));
  assign o_m_valid = i_s_valid && w_allow;
  assign o_s_ready = i_m_ready && w_allow;
  assign w_issue   = i_s_valid && i_m_ready && w_allow;

  assign o_busy = (r_cnt != '0);
  assign o_port = r_port;
  assign o_err  = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_port  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_port  <= w_port_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_port_nxt  = r_port;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = CNT_WIDTH'(1);
          w_port_nxt  = i_req_port;
        end
        // Counter is zero here, so any completion is an underflow.
        if (i_done) begin
          w_err_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_issue && !i_done) begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end else if (!w_issue && i_done) begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
          if (r_cnt == CNT_WIDTH'(1)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/nasti_demux_order_ctrl.sv
// Keeps AR and AW traffic locked to one demux port at a time so same-ID responses stay in order.
module nasti_demux_order_ctrl
  import nasti_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_ar_valid,
  output logic       s_ar_ready,
  input  logic [2:0] ar_port,
  output logic       m_ar_valid,
  input  logic       m_ar_ready,
  input  logic       r_fire,
  input  logic       s_aw_valid,
  output logic       s_aw_ready,
  input  logic [2:0] aw_port,
  output logic       m_aw_valid,
  input  logic       m_aw_ready,
  input  logic       b_fire,
  output logic       rd_busy,
  output logic       wr_busy,
  output logic [2:0] rd_port,
  output logic [2:0] wr_port,
  output logic       proto_err
);

  logic w_rd_err;
  logic w_wr_err;

  nasti_txn_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_rd_tracker (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_s_valid (s_ar_valid),
    .o_s_ready (s_ar_ready),
    .i_req_port(ar_port),
    .o_m_valid (m_ar_valid),
    .i_m_ready (m_ar_ready),
    .i_done    (r_fire),
    .o_busy    (rd_busy),
    .o_port    (rd_port),
    .o_err     (w_rd_err)
  );

  nasti_txn_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_wr_tracker (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_s_valid (s_aw_valid),
    .o_s_ready (s_aw_ready),
    .i_req_port(aw_port),
    .o_m_valid (m_aw_valid),
    .i_m_ready (m_aw_ready),
    .i_done    (b_fire),
    .o_busy    (wr_busy),
    .o_port    (wr_port),
    .o_err     (w_wr_err)
  );

  assign proto_err = w_rd_err | w_wr_err;

endmodule

// File: tb/tb_nasti_demux_order_ctrl.sv
// Scoreboard bench: per-cycle expectations from an in-flight-burst queue model, checked by a separate monitor.
module tb_nasti_demux_order_ctrl;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_ar_valid = 1'b0, m_ar_ready = 1'b0, r_fire = 1'b0;
  logic       s_aw_valid = 1'b0, m_aw_ready = 1'b0, b_fire = 1'b0;
  logic [2:0] ar_port = '0, aw_port = '0;
  logic       s_ar_ready, m_ar_valid, s_aw_ready, m_aw_valid;
  logic       rd_busy, wr_busy, proto_err;
  logic [2:0] rd_port, wr_port;

  always #5 clk = ~clk;

  nasti_demux_order_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_ar_valid(s_ar_valid),
    .s_ar_ready(s_ar_ready),
    .ar_port   (ar_port),
    .m_ar_valid(m_ar_valid),
    .m_ar_ready(m_ar_ready),
    .r_fire    (r_fire),
    .s_aw_valid(s_aw_valid),
    .s_aw_ready(s_aw_ready),
    .aw_port   (aw_port),
    .m_aw_valid(m_aw_valid),
    .m_aw_ready(m_aw_ready),
    .b_fire    (b_fire),
    .rd_busy   (rd_busy),
    .wr_busy   (wr_busy),
    .rd_port   (rd_port),
    .wr_port   (wr_port),
    .proto_err (proto_err)
  );

  typedef struct {
    bit mArValid, sArReady, mAwValid, sAwReady;
    bit rdBusy, wrBusy, protoErr;
    int rdPort, wrPort;
    int stepNo;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   step = 0;

  // Reference model: ports of bursts in flight per channel, oldest first.
  int rdQ[$];
  int wrQ[$];
  int lastRdPort = 0;
  int lastWrPort = 0;
  bit modelErr = 0;
  bit arIssued = 0;
  bit awIssued = 0;

  function automatic bit allowed(input int qSize, input int head, input int port);
    return (qSize == 0) || ((port == head) && (qSize < MAX));
  endfunction

  task automatic applyStimulus(input bit iRst, input bit iArV, input int iArP, input bit iArR,
                               input bit iRF, input bit iAwV, input int iAwP, input bit iAwR,
                               input bit iBF);
    exp_t e;
    bit   arAllow, awAllow;
    @(posedge clk);
    #1;
    rst = iRst;
    s_ar_valid = iArV; ar_port = 3'(iArP); m_ar_ready = iArR; r_fire = iRF;
    s_aw_valid = iAwV; aw_port = 3'(iAwP); m_aw_ready = iAwR; b_fire = iBF;
    step++;
    if (iRst) begin
      rdQ.delete(); wrQ.delete();
      lastRdPort = 0; lastWrPort = 0; modelErr = 0;
      arIssued = 0; awIssued = 0;
      return;
    end
    arAllow = allowed(rdQ.size(), (rdQ.size() > 0) ? rdQ[0] : 0, iArP);
    awAllow = allowed(wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 0, iAwP);
    e.mArValid = iArV && arAllow;
    e.sArReady = iArR && arAllow;
    e.mAwValid = iAwV && awAllow;
    e.sAwReady = iAwR && awAllow;
    e.rdBusy   = (rdQ.size() != 0);
    e.wrBusy   = (wrQ.size() != 0);
    e.rdPort   = lastRdPort;
    e.wrPort   = lastWrPort;
    e.protoErr = modelErr;
    e.stepNo   = step;
    expQ.push_back(e);
    arIssued = iArV && iArR && arAllow;
    awIssued = iAwV && iAwR && awAllow;
    if (iRF) begin
      if (rdQ.size() > 0) void'(rdQ.pop_front());
      else modelErr = 1;
    end
    if (arIssued) begin
      rdQ.push_back(iArP);
      lastRdPort = iArP;
    end
    if (iBF) begin
      if (wrQ.size() > 0) void'(wrQ.pop_front());
      else modelErr = 1;
    end
    if (awIssued) begin
      wrQ.push_back(iAwP);
      lastWrPort = iAwP;
    end
  endtask

  task automatic checkField(input string name, input logic [31:0] actual,
                            input logic [31:0] expected, input int stepNo);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at step %0d: got %0d, expected %0d", name, stepNo, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("m_ar_valid", {31'b0, m_ar_valid}, {31'b0, e.mArValid}, e.stepNo);
    checkField("s_ar_ready", {31'b0, s_ar_ready}, {31'b0, e.sArReady}, e.stepNo);
    checkField("m_aw_valid", {31'b0, m_aw_valid}, {31'b0, e.mAwValid}, e.stepNo);
    checkField("s_aw_ready", {31'b0, s_aw_ready}, {31'b0, e.sAwReady}, e.stepNo);
    checkField("rd_busy", {31'b0, rd_busy}, {31'b0, e.rdBusy}, e.stepNo);
    checkField("wr_busy", {31'b0, wr_busy}, {31'b0, e.wrBusy}, e.stepNo);
    checkField("rd_port", {29'b0, rd_port}, 32'(e.rdPort), e.stepNo);
    checkField("wr_port", {29'b0, wr_port}, 32'(e.wrPort), e.stepNo);
    checkField("proto_err", {31'b0, proto_err}, {31'b0, e.protoErr}, e.stepNo);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit arV, awV, arR, awR, rF, bF, doRst;
    int arP, awP;

    $display("[TB] reset and single AR to port 2");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 1, 7, 0, 0);
    applyStimulus(0, 1, 2, 1, 0, 0, 0, 0, 0);
    idleCycle();

    $display("[TB] port switch stalls until the last read completes");
    applyStimulus(0, 1, 2, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 0);
    idleCycle();

    $display("[TB] simultaneous issue and completion at count 1");
    applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 0);
    idleCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idleCycle();

    $display("[TB] write channel fills to the outstanding limit");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idleCycle();

    $display("[TB] read lock does not affect writes");
    applyStimulus(0, 1, 3, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4, 1, 0, 1, 6, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    idleCycle();

    $display("[TB] underflow is sticky until reset");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idleCycle();
    applyStimulus(0, 1, 7, 1, 1, 0, 0, 0, 0);
    idleCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycle();

    $display("[TB] randomized traffic");
    arV = 0; awV = 0; arP = 0; awP = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(arV && !arIssued)) begin
        arV = ($urandom_range(0, 1) == 1);
        arP = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1));
      end
      if (!(awV && !awIssued)) begin
        awV = ($urandom_range(0, 1) == 1);
        awP = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1));
      end
      arR = ($urandom_range(0, 3) != 0);
      awR = ($urandom_range(0, 3) != 0);
      rF = (rdQ.size() > 0) && ($urandom_range(0, 2) == 0);
      bF = (wrQ.size() > 0) && ($urandom_range(0, 2) == 0);
      doRst = ($urandom_range(0, 599) == 0);
      applyStimulus(doRst, arV, arP, arR, rF, awV, awP, awR, bF);
      if (doRst) begin
        arV = 0;
        awV = 0;
      end
    end
    idleCycle();

    for (int t = 0; t < 10 && expQ.size() > 0; t++) @(posedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
